multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Main control FSM for the multicycle CPU. Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath select and write enable. It supplies the raw `FlagsWrite` request to the conditional unit and gates architectural writes with the instruction's condition result. That result is latched at decode. Sits between the instruction register / conditional unit and the datapath muxes.

## Interface
Parameters: none.

Clock and reset:
- Single clock domain.
- Reset is asynchronous and active-low.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `Op`  in  2  instruction op field: 00 data-processing, 01 memory, 10 branch, 11 illegal
- `Funct`  in  6  encoding per op class:
  - Data-processing: [5]=I (immediate), [4:1]=cmd, [0]=S.
  - Memory: [0]=L (load).
- `Rd`  in  4  destination register
- `CondEx`  in  1  condition result from the conditional unit (EQ or always)
- `mem_ready`  in  1  memory has completed the current access this cycle
- `PCWrite`  out  1  PC write enable
- `AdrSrc`  out  1  0=PC, 1=ALU result
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  instruction register write enable
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  00=ALUOut, 01=Data, 10=ALU result
- `ALUSrcA`  out  1  0=register A, 1=PC
- `ALUSrcB`  out  2  00=register B, 01=ExtImm, 10=constant 4
- `ALUControl`  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- `FlagsWrite`  out  2  [1]=N,Z update; [0]=C,V update
- `illegal`  out  1  sticky: an Op=11 instruction was decoded
- `state`  out  4  current FSM state (debug)

## Operation
FSM state encodings:

| State | Code |
|---|---|
| FETCH | 0 |
| DECODE | 1 |
| MEMADR | 2 |
| MEMREAD | 3 |
| MEMWB | 4 |
| MEMWRITE | 5 |
| EXECUTER | 6 |
| EXECUTEI | 7 |
| ALUWB | 8 |
| BRANCH | 9 |

Codes 10–15 are unused and go to FETCH on the next cycle with all enables 0.

Transitions:
- FETCH: holds while `mem_ready`=0. Goes to DECODE when `mem_ready`=1.
- DECODE, by `Op`:
  - Op 00: EXECUTEI if Funct[5]=1, else EXECUTER.
  - Op 01: MEMADR.
  - Op 10: BRANCH.
  - Op 11: FETCH, and sets `illegal`.
- EXECUTER / EXECUTEI: go to ALUWB, except CMP (cmd 1010), which goes to FETCH.
- MEMADR: MEMREAD if L=1, else MEMWRITE.
- MEMREAD: holds until `mem_ready`=1, then MEMWB.
- MEMWRITE: holds until `mem_ready`=1, then FETCH.
- MEMWB, ALUWB, BRANCH: go to FETCH.

Condition latch:
- `cond_ok` register is loaded from `CondEx` in DECODE.
- Every write enable outside FETCH/DECODE is ANDed with `cond_ok`. This covers RegWrite, MemWrite, the non-fetch PCWrite and FlagsWrite.

Per-state outputs (anything not listed is 0 / 00):
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - IRWrite=PCWrite=`mem_ready`.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 (computes PC+8). No write enables.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
- MEMREAD: AdrSrc=1.
- MEMWRITE: AdrSrc=1, MemWrite=`cond_ok`. Held every wait cycle until `mem_ready`.
- MEMWB: ResultSrc=01, RegWrite=`cond_ok`.
- EXECUTER: ALUSrcA=0, ALUSrcB=00.
- EXECUTEI: ALUSrcA=0, ALUSrcB=01.
- EXECUTER / EXECUTEI ALU decode by cmd:

  | cmd | Operation | ALUControl |
  |---|---|---|
  | 0100 | ADD | 00 |
  | 0010 | SUB | 01 |
  | 1010 | CMP | 01 |
  | 0000 | AND | 10 |
  | 1100 | ORR | 11 |

  Any other cmd is treated as ADD.
- EXECUTER / EXECUTEI flags:
  - FlagsWrite[1] = (S | CMP) & `cond_ok`.
  - FlagsWrite[0] = (S | CMP) & (cmd is ADD/SUB/CMP) & `cond_ok`.
- ALUWB:
  - ResultSrc=00, RegWrite=`cond_ok`.
  - PCWrite=`cond_ok` & (Rd==15).
- BRANCH:
  - ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, ResultSrc=10.
  - PCWrite=`cond_ok`.

`illegal`:
- Set in DECODE when Op=11.
- Cleared only by reset.

## Timing
Reset:
- While `rst_n`=0: state=FETCH, `cond_ok`=0, `illegal`=0, and all write enables are forced to 0, even if `mem_ready`=1.
- Release is sampled at the next `clk` edge.
- Reset asserted mid-instruction (including a MEMWRITE wait) aborts it immediately. No further writes are issued.

Outputs:
- All outputs are a Moore function of state and `cond_ok`.
- The only Mealy terms are the `mem_ready` gating in FETCH, and `Funct`/`Rd` decode in EXECUTE/ALUWB.

Latency with `mem_ready`=1 throughout:

| Instruction | Cycles |
|---|---|
| data-processing | 4 |
| CMP | 3 |
| LDR | 5 |
| STR | 4 |
| B | 3 |
| illegal | 2 |

Each wait cycle adds 1 cycle in FETCH, MEMREAD or MEMWRITE.

Handshake: a memory request is held (same outputs) until `mem_ready` is sampled 1. It completes on that edge.

## Test plan
- ADD with S=1 (Op=00, Funct=001001), `mem_ready` low 2 cycles in FETCH, CondEx=1:
  - IRWrite=PCWrite=1 only on the third FETCH cycle.
  - FlagsWrite=11 in EXECUTER; RegWrite=1 in ALUWB.
  - Total 6 cycles.
- CMP (Funct=010101) followed by ADDEQ with the Z flag clear (CondEx=0 at decode):
  - CMP: FlagsWrite=11, returns to FETCH after 3 cycles.
  - ADDEQ: RegWrite=0 and FlagsWrite=00 throughout.
- LDR (Op=01, Funct[0]=1), `mem_ready` low 3 cycles in MEMREAD:
  - AdrSrc=1 held for 4 cycles.
  - RegWrite=1 with ResultSrc=01 in MEMWB.
- STR taken vs not taken:
  - CondEx=1: MemWrite=1 during MEMWRITE.
  - CondEx=0: MemWrite=0, state still returns to FETCH.
- Branch (Op=10): PCWrite=1 in BRANCH when taken, 0 when not taken; 3 cycles each.
- Op=11:
  - `illegal` rises after DECODE and stays 1 across later instructions.
  - `rst_n` pulse during a MEMREAD wait: state=0 and `illegal`=0 immediately, and no RegWrite occurs.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle CPU.
// Each instruction passes through fetch, decode, execute, memory and
// writeback. The FSM drives every datapath select and write enable, and
// gates architectural writes with the condition result latched at decode.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   Op, Funct, Rd         instruction fields from the instruction register
//   CondEx                condition result from the conditional unit
//   mem_ready             memory finishes the current access this cycle
//   PCWrite .. FlagsWrite datapath selects and write enables
//   illegal               sticky flag, set when an Op=11 instruction is decoded
//   state                 current FSM state (debug)
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagsWrite,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     cur, nxt;
  logic       cond_ok;
  logic [3:0] cmd;
  logic       is_cmp;
  logic       is_arith;
  logic       set_flags;
  logic [1:0] alu_ctl;

  assign state     = cur;
  assign cmd       = Funct[4:1];
  assign is_cmp    = (cmd == 4'b1010);
  assign is_arith  = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;
  assign set_flags = Funct[0] | is_cmp;

  // ALU operation decode; unknown commands fall back to ADD
  always_comb begin
    alu_ctl = 2'b00;
    case (cmd)
      4'b0010, 4'b1010: alu_ctl = 2'b01;
      4'b0000:          alu_ctl = 2'b10;
      4'b1100:          alu_ctl = 2'b11;
      default:          alu_ctl = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= FETCH;
    else        cur <= nxt;
  end

  // Condition latch and sticky illegal flag, both captured in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_ok <= 1'b0;
      illegal <= 1'b0;
    end else if (cur == DECODE) begin
      cond_ok <= CondEx;
      if (Op == 2'b11) illegal <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   nxt = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   nxt = MEMADR;
          2'b10:   nxt = BRANCH;
          default: nxt = FETCH;
        endcase
      end
      EXECUTER, EXECUTEI: nxt = is_cmp ? FETCH : ALUWB;
      MEMADR:   nxt = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = mem_ready ? MEMWB : MEMREAD;
      MEMWRITE: nxt = mem_ready ? FETCH : MEMWRITE;
      default:  nxt = FETCH;
    endcase
  end

  // Output decode; enables past DECODE are qualified by cond_ok
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    FlagsWrite = 2'b00;
    case (cur)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        // rst_n term keeps fetch writes off while reset is held
        IRWrite   = mem_ready & rst_n;
        PCWrite   = mem_ready & rst_n;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ok;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ok;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (cur == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
        FlagsWrite = {set_flags & cond_ok, set_flags & is_arith & cond_ok};
      end
      ALUWB: begin
        RegWrite = cond_ok;
        PCWrite  = cond_ok & (Rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ok;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, illegal;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, FlagsWrite;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Rd(Rd),
    .CondEx(CondEx), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .FlagsWrite(FlagsWrite),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aluc;
    logic [1:0] fw;
    logic       ill;
  } exp_t;

  int checks = 0;
  int failures = 0;

  exp_t q[$];
  bit   mrq[$];
  bit   cxq[$];
  bit   model_ill = 1'b0;

  // DUT activity seen over the last run, pinned against literals afterwards
  int   ncyc;
  bit   or_regw, or_memw, or_pcw_nf;
  logic [1:0] or_fw;

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e = '0;
    e.st  = st;
    e.ill = model_ill;
    return e;
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 2'b01;
      4'b0000:          return 2'b10;
      4'b1100:          return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction

  task automatic push(input exp_t e, input bit mr, input bit cx);
    q.push_back(e); mrq.push_back(mr); cxq.push_back(cx);
  endtask

  // Expected per-cycle output trace of one instruction, from the instruction's semantics
  task automatic build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                       input bit cx, input int fwait, input int mwait);
    exp_t e;
    logic [3:0] cmd = fn[4:1];
    bit cmp = (cmd == 4'b1010);
    bit arith = (cmd == 4'b0100) || (cmd == 4'b0010) || cmp;
    bit sf = fn[0] | cmp;
    q.delete(); mrq.delete(); cxq.delete();
    Op = op; Funct = fn; Rd = rd;
    for (int i = 0; i < fwait; i++) begin
      e = blank(4'd0); e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; push(e, 0, ~cx);
    end
    e = blank(4'd0); e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; e.irw = 1; e.pcw = 1;
    push(e, 1, ~cx);
    e = blank(4'd1); e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; push(e, 1, cx);
    if (op == 2'b11) begin
      model_ill = 1'b1;
      return;
    end
    case (op)
      2'b00: begin
        e = blank(fn[5] ? 4'd7 : 4'd6);
        e.asb = fn[5] ? 2'b01 : 2'b00;
        e.aluc = alu_of(cmd);
        e.fw = {sf & cx, sf & arith & cx};
        push(e, 1, ~cx);
        if (!cmp) begin
          e = blank(4'd8); e.regw = cx; e.pcw = cx && (rd == 4'd15); push(e, 1, ~cx);
        end
      end
      2'b01: begin
        e = blank(4'd2); e.asb = 2'b01; push(e, 1, ~cx);
        if (fn[0]) begin
          for (int i = 0; i <= mwait; i++) begin
            e = blank(4'd3); e.adr = 1; push(e, i == mwait, ~cx);
          end
          e = blank(4'd4); e.rs = 2'b01; e.regw = cx; push(e, 1, ~cx);
        end else begin
          for (int i = 0; i <= mwait; i++) begin
            e = blank(4'd5); e.adr = 1; e.memw = cx; push(e, i == mwait, ~cx);
          end
        end
      end
      default: begin
        e = blank(4'd9); e.asb = 2'b01; e.rs = 2'b10; e.pcw = cx; push(e, 1, ~cx);
      end
    endcase
  endtask

  // Drive and compare every cycle of the built trace (n<0: whole trace)
  task automatic run(input string name, input int n);
    exp_t got;
    int lim = (n < 0) ? q.size() : n;
    ncyc = 0; or_regw = 0; or_memw = 0; or_pcw_nf = 0; or_fw = 2'b00;
    for (int i = 0; i < lim; i++) begin
      mem_ready = mrq[i];
      CondEx = cxq[i];
      @(negedge clk);
      got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, FlagsWrite, illegal};
      checks++;
      if (got !== q[i]) begin
        failures++;
        $display("FAIL %s cycle %0d: got=%h exp=%h", name, i, got, q[i]);
      end
      ncyc++;
      or_regw |= RegWrite; or_memw |= MemWrite; or_fw |= FlagsWrite;
      if (state != 4'd0) or_pcw_nf |= PCWrite;
      @(posedge clk); #1;
    end
  endtask

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic do_instr(input string name, input logic [1:0] op, input logic [5:0] fn,
                          input logic [3:0] rd, input bit cx, input int fw_, input int mw,
                          input int want_cyc);
    build(op, fn, rd, cx, fw_, mw);
    pin({name, "_modellen"}, q.size(), want_cyc);
    run(name, -1);
    pin({name, "_cycles"}, ncyc, want_cyc);
  endtask

  initial begin
    rst_n = 1'b0; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pin("rst_state", state, 0);
    pin("rst_irwrite", IRWrite, 0);
    pin("rst_pcwrite", PCWrite, 0);
    pin("rst_illegal", illegal, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_instr("add_s_fwait", 2'b00, 6'b001001, 4'd3, 1, 2, 0, 6);
    pin("add_s_fw", or_fw, 3); pin("add_s_regw", or_regw, 1);
    do_instr("cmp", 2'b00, 6'b010101, 4'd0, 1, 0, 0, 3);
    pin("cmp_fw", or_fw, 3); pin("cmp_regw", or_regw, 0);
    do_instr("addeq_nt", 2'b00, 6'b001000, 4'd2, 0, 0, 0, 4);
    pin("addeq_fw", or_fw, 0); pin("addeq_regw", or_regw, 0);
    do_instr("addi_r15", 2'b00, 6'b101000, 4'd15, 1, 0, 0, 4);
    pin("addi_r15_pcw", or_pcw_nf, 1); pin("addi_r15_fw", or_fw, 0);
    do_instr("orr_s", 2'b00, 6'b011001, 4'd1, 1, 0, 0, 4);
    pin("orr_s_fw", or_fw, 2);
    do_instr("and_s", 2'b00, 6'b000001, 4'd1, 1, 1, 0, 5);
    do_instr("subi_s", 2'b00, 6'b100101, 4'd4, 1, 0, 0, 4);
    do_instr("unk_cmd", 2'b00, 6'b011110, 4'd5, 1, 0, 0, 4);
    do_instr("ldr_wait", 2'b01, 6'b000001, 4'd6, 1, 0, 3, 8);
    pin("ldr_regw", or_regw, 1);
    do_instr("str_t", 2'b01, 6'b000000, 4'd0, 1, 0, 1, 5);
    pin("str_t_memw", or_memw, 1);
    do_instr("str_nt", 2'b01, 6'b000000, 4'd0, 0, 0, 2, 6);
    pin("str_nt_memw", or_memw, 0);
    do_instr("b_t", 2'b10, 6'b000000, 4'd0, 1, 0, 0, 3);
    pin("b_t_pcw", or_pcw_nf, 1);
    do_instr("b_nt", 2'b10, 6'b000000, 4'd0, 0, 0, 0, 3);
    pin("b_nt_pcw", or_pcw_nf, 0);
    do_instr("illegal_op", 2'b11, 6'b000000, 4'd0, 1, 0, 0, 2);
    pin("illegal_set", illegal, 1);
    do_instr("after_ill", 2'b00, 6'b001000, 4'd7, 1, 0, 0, 4);
    pin("illegal_sticky", illegal, 1);

    // Reset in the middle of a MEMREAD wait
    build(2'b01, 6'b000001, 4'd8, 1, 0, 5);
    run("ldr_abort", 5);
    pin("pre_abort_state", state, 3);
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    pin("abort_state", state, 0);
    pin("abort_illegal", illegal, 0);
    pin("abort_regw", RegWrite, 0);
    pin("abort_irw", IRWrite, 0);
    or_regw = 0;
    repeat (3) begin
      @(negedge clk);
      or_regw |= RegWrite | IRWrite | PCWrite | MemWrite;
    end
    pin("abort_no_writes", or_regw, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ill = 1'b0;
    do_instr("post_rst_add", 2'b00, 6'b001001, 4'd9, 1, 0, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
